// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Holds the response-pipe entry type, the ECALL encoding and the fetch-address legality check.
package instr_mem_pkg;

  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rsp_entry_t;

  // A fetch is legal when it is word aligned and falls inside the RAM.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/instr_rsp_pipe.sv
// Fixed-length response shift register; entry_o is the entry issued to the core this cycle.
// Payload bits only move with a valid entry, so the output data holds between responses.
module instr_rsp_pipe
  import instr_mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       flush_i,
  input  rsp_entry_t entry_i,
  output rsp_entry_t entry_o
);

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      rsp_entry_t src;
      rsp_entry_t q;

      if (gi == 0) begin : g_head
        assign src = entry_i;
      end else begin : g_tail
        assign src = g_stage[gi-1].q;
      end

      always_ff @(posedge clk) begin
        if (flush_i) begin
          q <= '0;
        end else begin
          q.valid <= src.valid;
          if (src.valid) begin
            q.err  <= src.err;
            q.data <= src.data;
          end
        end
      end
    end
  endgenerate

  assign entry_o = g_stage[LATENCY-1].q;

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side end of the MR1 instruction-fetch interface: word RAM with a backdoor load port,
// fixed-latency in-order responses and a bounded number of outstanding fetches.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_DATA        = ECALL_INSN,
  localparam int         AW              = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_req_valid,
  output logic          instr_req_ready,
  input  logic [31:0]   instr_req_addr,
  output logic          instr_rsp_valid,
  output logic [31:0]   instr_rsp_data,
  output logic          instr_rsp_err,
  input  logic          stall_in,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [2:0]    outstanding
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_data;
  logic        addr_good;
  logic        accept;
  logic        retire;
  logic [2:0]  outstanding_q, outstanding_d;
  rsp_entry_t  entry_in;
  rsp_entry_t  entry_out;

  // Read happens in the accept cycle, so a same-cycle load still returns the old word.
  always_ff @(posedge clk) begin
    if (load_valid) begin
      mem[load_addr] <= load_data;
    end
  end

  assign rd_data   = mem[instr_req_addr[2 +: AW]];
  assign addr_good = addr_ok(instr_req_addr, DEPTH_WORDS);

  assign retire          = entry_out.valid;
  assign instr_req_ready = !reset && !stall_in &&
                           ((outstanding_q < 3'(MAX_OUTSTANDING)) || retire);
  assign accept          = instr_req_valid && instr_req_ready;

  always_comb begin
    entry_in       = '0;
    entry_in.valid = accept;
    entry_in.err   = !addr_good;
    entry_in.data  = addr_good ? rd_data : ERR_DATA;
  end

  instr_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .flush_i (reset),
    .entry_i (entry_in),
    .entry_o (entry_out)
  );

  always_comb begin
    outstanding_d = outstanding_q + {2'b00, accept} - {2'b00, retire};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign instr_rsp_valid = entry_out.valid;
  assign instr_rsp_err   = entry_out.err;
  assign instr_rsp_data  = entry_out.data;
  assign outstanding     = outstanding_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: the driver queues the expected word and due cycle at
// each handshake, and a negedge monitor checks every response against the queue head.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_valid;
  logic        instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        instr_rsp_err;
  logic        stall_in;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic [2:0]  outstanding;

  instr_mem_responder #(
    .DEPTH_WORDS     (1024),
    .LATENCY         (2),
    .MAX_OUTSTANDING (2),
    .ERR_DATA        (32'h0000_0073)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_req_valid (instr_req_valid),
    .instr_req_ready (instr_req_ready),
    .instr_req_addr  (instr_req_addr),
    .instr_rsp_valid (instr_rsp_valid),
    .instr_rsp_data  (instr_rsp_data),
    .instr_rsp_err   (instr_rsp_err),
    .stall_in        (stall_in),
    .load_valid      (load_valid),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .outstanding     (outstanding)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   max_out = 0;

  // Monitor: every response must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && int'(outstanding) > max_out) max_out = int'(outstanding);
    if (instr_rsp_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: cycle %0d got data=%h err=%b, required no response",
                 cyc, instr_rsp_data, instr_rsp_err);
      end else begin
        e = sb.pop_front();
        if (instr_rsp_data !== e.data || instr_rsp_err !== e.err || cyc != e.due) begin
          fails++;
          $display("FAIL rsp_check: got data=%h err=%b cycle %0d, required data=%h err=%b cycle %0d",
                   instr_rsp_data, instr_rsp_err, cyc, e.data, e.err, e.due);
        end else begin
          $display("[TB] rsp cycle %0d data=%h err=%b ok", cyc, instr_rsp_data, instr_rsp_err);
        end
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      tests++;
      fails++;
      $display("FAIL rsp_missing: no response by cycle %0d, required data=%h err=%b at cycle %0d",
               cyc, sb[0].data, sb[0].err, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("[TB] check %s = %h ok", name, act);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    instr_req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Presents one fetch until accepted (bounded); leaves req_valid high for back-to-back use.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e,
                       input bit expect_rsp, output int waited);
    exp_t e;
    bit   accepted;
    accepted        = 1'b0;
    waited          = 0;
    instr_req_valid = 1'b1;
    instr_req_addr  = addr;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (instr_req_ready === 1'b1) begin
        accepted = 1'b1;
        if (expect_rsp) begin
          e.data = exp_d;
          e.err  = exp_e;
          e.due  = cyc + 2;
          sb.push_back(e);
        end
        $display("[TB] accept addr=%h cycle %0d", addr, cyc);
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: addr=%h not accepted in 20 cycles, required accept", addr);
    end
  endtask

  initial begin
    int w;
    reset           = 1'b1;
    instr_req_valid = 1'b0;
    instr_req_addr  = '0;
    stall_in        = 1'b0;
    load_valid      = 1'b0;
    load_addr       = '0;
    load_data       = '0;
    @(posedge clk); #1;

    // Backdoor loads while reset is held.
    load(10'd0, 32'h1111_1111);
    load(10'd1, 32'h2222_2222);
    load(10'd2, 32'h3333_3333);
    load(10'd3, 32'h4444_4444);
    load(10'd4, 32'h0020_80B3);

    @(negedge clk);
    check("reset_rsp_valid", instr_rsp_valid, 0);
    check("reset_rsp_err", instr_rsp_err, 0);
    check("reset_rsp_data", instr_rsp_data, 0);
    check("reset_outstanding", outstanding, 0);
    check("reset_ready", instr_req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single fetch.
    fetch(32'h10, 32'h0020_80B3, 1'b0, 1'b1, w);
    idle(4);

    // Stream: a retire frees a slot every cycle, so no waits.
    fetch(32'h0, 32'h1111_1111, 1'b0, 1'b1, w);
    check("stream_wait_0", w, 0);
    fetch(32'h4, 32'h2222_2222, 1'b0, 1'b1, w);
    check("stream_wait_4", w, 0);
    fetch(32'h8, 32'h3333_3333, 1'b0, 1'b1, w);
    check("stream_wait_8", w, 0);
    fetch(32'hC, 32'h4444_4444, 1'b0, 1'b1, w);
    check("stream_wait_c", w, 0);
    idle(4);

    // Bad addresses, then a good one.
    fetch(32'h2, 32'h0000_0073, 1'b1, 1'b1, w);
    fetch(32'h1000, 32'h0000_0073, 1'b1, 1'b1, w);
    fetch(32'h0, 32'h1111_1111, 1'b0, 1'b1, w);
    idle(4);

    // Stall: three blocked cycles while the earlier fetch drains on time.
    fetch(32'h10, 32'h0020_80B3, 1'b0, 1'b1, w);
    stall_in       = 1'b1;
    instr_req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", instr_req_ready, 0);
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
    fetch(32'h8, 32'h3333_3333, 1'b0, 1'b1, w);
    idle(4);

    // Load collision: same-cycle fetch sees the old word, the next one the new word.
    load_valid = 1'b1;
    load_addr  = 10'd0;
    load_data  = 32'hAAAA_AAAA;
    fetch(32'h0, 32'h1111_1111, 1'b0, 1'b1, w);
    load_valid = 1'b0;
    fetch(32'h0, 32'hAAAA_AAAA, 1'b0, 1'b1, w);
    idle(4);

    // Reset with two in flight: the second response must be dropped.
    fetch(32'h10, 32'h0020_80B3, 1'b0, 1'b1, w);
    fetch(32'h8, 32'h0, 1'b0, 1'b0, w);
    instr_req_valid = 1'b0;
    reset           = 1'b1;
    @(negedge clk);
    check("inflight_outstanding", outstanding, 2);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outstanding", outstanding, 0);
    check("post_reset_ready", instr_req_ready, 1);
    @(posedge clk); #1;
    idle(8);

    check("scoreboard_empty", sb.size(), 0);
    check("max_outstanding", max_out, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, required completion");
    $fatal(1, "watchdog");
  end

endmodule
